avmm_rd_responder: RTL and testbench

Avalon-MM read responder (slave side) that serves word-addressed 64-bit reads to the matrix-load master in the minilab datapath. It models the memory the master's fill state machine reads its B vector and A rows from. It has a parameterised stall (`waitrequest`) and a fixed read latency (`readdatavalid`), which lets the master's handshake be exercised on-chip and in simulation. A side write port preloads contents.

---
 rtl/avmm_rd_if.sv | 29 ++
 rtl/avmm_rd_responder.sv | 148 ++++++++++++++
 tb/tb_avmm_rd_responder.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/avmm_rd_if.sv
// Avalon-MM read channel bundle between the matrix-load master and the
// read responder. The master drives the command; the slave drives the
// stall and the returned data.
interface avmm_rd_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 32
) ();
    logic [ADDR_WIDTH-1:0] address;
    logic                  read;
    logic                  waitrequest;
    logic [DATA_WIDTH-1:0] readdata;
    logic                  readdatavalid;

    modport master (
        output address,
        output read,
        input  waitrequest,
        input  readdata,
        input  readdatavalid
    );

    modport slave (
        input  address,
        input  read,
        output waitrequest,
        output readdata,
        output readdatavalid
    );
endinterface

// File: rtl/avmm_rd_responder.sv
// Avalon-MM read responder: a small word-addressed memory that the
// matrix-load master reads from. Each command is stalled WAIT_CYCLES
// cycles, data returns in order LATENCY cycles after acceptance, and at
// most MAX_OUTSTANDING reads may be in flight. A side write port preloads
// the memory, whose contents survive reset.
module avmm_rd_responder #(
    parameter int    DATA_WIDTH      = 64,
    parameter int    ADDR_WIDTH      = 32,
    parameter int    DEPTH           = 16,
    parameter int    LATENCY         = 3,
    parameter int    WAIT_CYCLES     = 1,
    parameter int    MAX_OUTSTANDING = 2,
    parameter string INIT_FILE       = ""
) (
    input  logic                               clk,
    input  logic                               rst_n,
    avmm_rd_if.slave                           bus,
    input  logic                               wr_en,
    input  logic [$clog2(DEPTH)-1:0]           wr_addr,
    input  logic [DATA_WIDTH-1:0]              wr_data,
    output logic                               err_oor,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding
);

    localparam int IW = $clog2(DEPTH);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [LATENCY-1:0]    vld_pipe_r;
    logic [DATA_WIDTH-1:0] dat_pipe_r [LATENCY];
    logic [OW-1:0]         outstanding_r;
    logic                  err_oor_r;

    logic                  stall_done_s;
    logic                  full_s;
    logic                  wait_s;
    logic                  accept_s;
    logic                  in_range_s;
    logic [DATA_WIDTH-1:0] cap_data_s;
    logic                  rdv_s;

    // Stall counter: counts the stall cycles a pending command has paid.
    // With no stall configured the command is always ready on that account.
    if (WAIT_CYCLES == 0) begin : g_nostall
        assign stall_done_s = 1'b1;
    end else begin : g_stall
        localparam int SW = $clog2(WAIT_CYCLES + 1);
        logic [SW-1:0] stall_cnt_r;

        // Count stalled cycles while read is held; restart on accept or idle.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                stall_cnt_r <= '0;
            end else if (!bus.read || accept_s) begin
                stall_cnt_r <= '0;
            end else if (stall_cnt_r != SW'(WAIT_CYCLES)) begin
                stall_cnt_r <= stall_cnt_r + SW'(1);
            end
        end

        assign stall_done_s = (stall_cnt_r == SW'(WAIT_CYCLES));
    end

    assign full_s     = (outstanding_r == OW'(MAX_OUTSTANDING));
    assign in_range_s = (bus.address < ADDR_WIDTH'(DEPTH));
    assign rdv_s      = vld_pipe_r[LATENCY-1];
    assign accept_s   = bus.read & ~wait_s;

    // Stall decision; held high during reset so nothing is accepted.
    always_comb begin
        wait_s = 1'b1;
        if (!rst_n) begin
            wait_s = 1'b1;
        end else if (bus.read) begin
            wait_s = ~stall_done_s | full_s;
        end else begin
            wait_s = 1'b0;
        end
    end

    // Word captured at the accept edge; out-of-range reads return zero.
    always_comb begin
        cap_data_s = '0;
        if (in_range_s) begin
            cap_data_s = mem_r[bus.address[IW-1:0]];
        end else begin
            cap_data_s = '0;
        end
    end

    // Preload write port; a same-edge read sees the previous contents.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Return pipeline: data only advances with its valid bit, so the last
    // stage holds the previous word while no beat is being returned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe_r <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                dat_pipe_r[i] <= '0;
            end
        end else begin
            vld_pipe_r[0] <= accept_s;
            if (accept_s) begin
                dat_pipe_r[0] <= cap_data_s;
            end
            for (int i = 1; i < LATENCY; i++) begin
                vld_pipe_r[i] <= vld_pipe_r[i-1];
                if (vld_pipe_r[i-1]) begin
                    dat_pipe_r[i] <= dat_pipe_r[i-1];
                end
            end
        end
    end

    // In-flight count: up on accept, down on a returned beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outstanding_r <= '0;
        end else begin
            case ({accept_s, rdv_s})
                2'b10:   outstanding_r <= outstanding_r + OW'(1);
                2'b01:   outstanding_r <= outstanding_r - OW'(1);
                default: outstanding_r <= outstanding_r;
            endcase
        end
    end

    // Sticky flag for any accepted read beyond the memory depth.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_oor_r <= 1'b0;
        end else if (accept_s && !in_range_s) begin
            err_oor_r <= 1'b1;
        end
    end

    assign bus.waitrequest   = wait_s;
    assign bus.readdata      = dat_pipe_r[LATENCY-1];
    assign bus.readdatavalid = rdv_s;
    assign err_oor           = err_oor_r;
    assign outstanding       = outstanding_r;

endmodule

// File: tb/tb_avmm_rd_responder.sv
// Bench for avmm_rd_responder: a queue-based model of the default
// configuration checked every cycle, directed scenarios with literal
// expectations, and a second instance exercising the in-flight limit.
module tb_avmm_rd_responder;

    localparam int A_W = 1;
    localparam int A_L = 3;
    localparam int A_M = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    logic        a_wr_en = 1'b0;
    logic [3:0]  a_wr_addr = 4'd0;
    logic [63:0] a_wr_data = 64'd0;
    logic        a_err;
    logic [1:0]  a_out;

    logic        b_wr_en = 1'b0;
    logic [3:0]  b_wr_addr = 4'd0;
    logic [63:0] b_wr_data = 64'd0;
    logic        b_err;
    logic [1:0]  b_out;

    int checks   = 0;
    int failures = 0;

    avmm_rd_if #(.DATA_WIDTH(64), .ADDR_WIDTH(32)) a_bus ();
    avmm_rd_if #(.DATA_WIDTH(64), .ADDR_WIDTH(32)) b_bus ();

    avmm_rd_responder #(
        .DATA_WIDTH(64), .ADDR_WIDTH(32), .DEPTH(16),
        .LATENCY(A_L), .WAIT_CYCLES(A_W), .MAX_OUTSTANDING(A_M)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(a_bus.slave),
        .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
        .err_oor(a_err), .outstanding(a_out)
    );

    avmm_rd_responder #(
        .DATA_WIDTH(64), .ADDR_WIDTH(32), .DEPTH(16),
        .LATENCY(4), .WAIT_CYCLES(0), .MAX_OUTSTANDING(2)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(b_bus.slave),
        .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
        .err_oor(b_err), .outstanding(b_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic fail_to(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=timeout required=event", name);
    endtask

    // ---------------- behavioural model of dut_a ----------------
    typedef struct {
        int          due;
        logic [63:0] data;
    } beat_t;

    beat_t       pend[$];
    logic [63:0] mdl_mem [16];
    logic [63:0] m_data   = 64'd0;
    bit          m_err    = 1'b0;
    int          m_waited = 0;
    int          ecnt     = 0;

    // Compare dut_a with the model, then advance the model across the next edge.
    always @(negedge clk) begin
        bit    e_rdv;
        bit    e_wr;
        beat_t b;
        if (!rst_n) begin
            pend.delete();
            m_data   = 64'd0;
            m_err    = 1'b0;
            m_waited = 0;
            chk("mdl_rst_waitrequest", {63'd0, a_bus.waitrequest}, 64'd1);
            chk("mdl_rst_rdv", {63'd0, a_bus.readdatavalid}, 64'd0);
            chk("mdl_rst_readdata", a_bus.readdata, 64'd0);
            chk("mdl_rst_outstanding", {62'd0, a_out}, 64'd0);
            chk("mdl_rst_err", {63'd0, a_err}, 64'd0);
        end else begin
            e_rdv = (pend.size() > 0) && (pend[0].due == ecnt);
            if (e_rdv) m_data = pend[0].data;
            e_wr = a_bus.read && ((m_waited < A_W) || (pend.size() == A_M));
            chk("mdl_waitrequest", {63'd0, a_bus.waitrequest}, {63'd0, e_wr});
            chk("mdl_rdv", {63'd0, a_bus.readdatavalid}, {63'd0, e_rdv});
            chk("mdl_readdata", a_bus.readdata, m_data);
            chk("mdl_outstanding", {62'd0, a_out}, 64'(pend.size()));
            chk("mdl_err", {63'd0, a_err}, {63'd0, m_err});
            if (e_rdv) void'(pend.pop_front());
            if (a_bus.read && !e_wr) begin
                b.due  = ecnt + A_L;
                b.data = (a_bus.address < 32'd16) ? mdl_mem[a_bus.address[3:0]] : 64'd0;
                pend.push_back(b);
                if (a_bus.address >= 32'd16) m_err = 1'b1;
                m_waited = 0;
            end else if (a_bus.read) begin
                m_waited++;
            end else begin
                m_waited = 0;
            end
        end
        if (a_wr_en) mdl_mem[a_wr_addr] = a_wr_data;
        ecnt++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic a_write(input logic [3:0] idx, input logic [63:0] d);
        @(posedge clk); #1;
        a_wr_en = 1'b1; a_wr_addr = idx; a_wr_data = d;
        @(posedge clk); #1;
        a_wr_en = 1'b0;
    endtask

    task automatic a_read(input logic [31:0] addr, output logic [63:0] data);
        bit got;
        data = 64'd0;
        @(posedge clk); #1;
        a_bus.read = 1'b1; a_bus.address = addr;
        got = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            if (!a_bus.waitrequest) got = 1'b1;
        end
        @(posedge clk); #1;
        a_bus.read = 1'b0;
        if (!got) begin
            fail_to("a_read_accept");
            return;
        end
        got = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            if (a_bus.readdatavalid) begin
                got  = 1'b1;
                data = a_bus.readdata;
            end
        end
        if (!got) fail_to("a_read_return");
    endtask

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed scenarios ----------------
    initial begin
        logic [63:0] d;
        logic [63:0] beats[$];
        logic [7:0]  b_wr_tab;
        logic [7:0]  b_rdv_tab;
        int          b_out_tab[8];
        int          acc;
        int          maxo;
        int          nb;
        bit          step;
        bit          got;

        a_bus.read = 1'b0; a_bus.address = 32'd0;
        b_bus.read = 1'b0; b_bus.address = 32'd0;
        b_wr_tab  = 8'b1001_1100;
        b_rdv_tab = 8'b0011_0000;
        b_out_tab = '{0, 1, 2, 2, 2, 1, 1, 2};

        // Preload while held in reset; memory has no reset.
        for (int k = 0; k < 16; k++) begin
            a_write(4'(k), (k == 0) ? 64'h0102030405060708 : 64'(k) * 64'h1111);
        end
        @(posedge clk); #1;
        b_wr_en = 1'b1; b_wr_addr = 4'd0; b_wr_data = 64'hB0B0B0B0B0B0B0B0;
        @(posedge clk); #1;
        b_wr_en = 1'b0;
        @(negedge clk);
        chk("rst_waitrequest_forced", {63'd0, a_bus.waitrequest}, 64'd1);

        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_waitrequest", {63'd0, a_bus.waitrequest}, 64'd0);
        chk("idle_rdv", {63'd0, a_bus.readdatavalid}, 64'd0);
        chk("idle_outstanding", {62'd0, a_out}, 64'd0);

        // Single read: one stall cycle, then data three cycles after accept.
        @(posedge clk); #1;
        a_bus.read = 1'b1; a_bus.address = 32'd0;
        @(negedge clk); chk("single_stall", {63'd0, a_bus.waitrequest}, 64'd1);
        @(negedge clk); chk("single_ready", {63'd0, a_bus.waitrequest}, 64'd0);
        @(posedge clk); #1;
        a_bus.read = 1'b0;
        @(negedge clk); chk("single_lat0", {63'd0, a_bus.readdatavalid}, 64'd0);
        @(negedge clk); chk("single_lat1", {63'd0, a_bus.readdatavalid}, 64'd0);
        @(negedge clk); chk("single_rdv", {63'd0, a_bus.readdatavalid}, 64'd1);
        chk("single_data", a_bus.readdata, 64'h0102030405060708);
        @(negedge clk); chk("single_one_beat", {63'd0, a_bus.readdatavalid}, 64'd0);
        chk("single_hold", a_bus.readdata, 64'h0102030405060708);

        // Burst 0..9 with the address stepping on every accept.
        a_write(4'd0, 64'd0);
        @(posedge clk); #1;
        a_bus.read = 1'b1; a_bus.address = 32'd0;
        acc = 0; maxo = 0;
        for (int n = 0; n < 200 && beats.size() < 10; n++) begin
            @(negedge clk);
            if (a_bus.readdatavalid) beats.push_back(a_bus.readdata);
            if (int'(a_out) > maxo) maxo = int'(a_out);
            step = a_bus.read && !a_bus.waitrequest;
            @(posedge clk); #1;
            if (step) begin
                acc++;
                if (acc == 10) a_bus.read = 1'b0;
                else a_bus.address = 32'(acc);
            end
        end
        a_bus.read = 1'b0;
        chk("burst_count", 64'(beats.size()), 64'd10);
        for (int k = 0; k < beats.size(); k++) begin
            chk($sformatf("burst_beat%0d", k), beats[k], 64'(k) * 64'h1111);
        end
        chk("burst_max_outstanding", {63'd0, maxo <= 2}, 64'd1);
        chk("burst_err", {63'd0, a_err}, 64'd0);

        // Out of range, then an in-range read: flag stays set.
        a_read(32'd16, d);
        chk("oor_data", d, 64'd0);
        chk("oor_err", {63'd0, a_err}, 64'd1);
        a_read(32'd3, d);
        chk("oor_next_data", d, 64'h3333);
        chk("oor_sticky", {63'd0, a_err}, 64'd1);

        // Write and accepted read on the same edge at index 5.
        a_write(4'd5, 64'h5555555555555555);
        @(posedge clk); #1;
        a_bus.read = 1'b1; a_bus.address = 32'd5;
        @(posedge clk); #1;
        a_wr_en = 1'b1; a_wr_addr = 4'd5; a_wr_data = 64'hAAAAAAAAAAAAAAAA;
        @(negedge clk); chk("coll_accept", {63'd0, a_bus.waitrequest}, 64'd0);
        @(posedge clk); #1;
        a_bus.read = 1'b0; a_wr_en = 1'b0;
        got = 1'b0;
        for (int n = 0; n < 10 && !got; n++) begin
            @(negedge clk);
            if (a_bus.readdatavalid) begin
                got = 1'b1;
                chk("coll_old_data", a_bus.readdata, 64'h5555555555555555);
            end
        end
        if (!got) fail_to("coll_return");
        a_read(32'd5, d);
        chk("coll_new_data", d, 64'hAAAAAAAAAAAAAAAA);

        // Reset with two reads in flight.
        a_write(4'd0, 64'h0102030405060708);
        @(posedge clk); #1;
        a_bus.read = 1'b1; a_bus.address = 32'd1;
        acc = 0;
        for (int n = 0; n < 40 && acc < 2; n++) begin
            @(negedge clk);
            if (!a_bus.waitrequest) acc++;
        end
        if (acc < 2) fail_to("rst_accepts");
        @(posedge clk); #1;
        a_bus.read = 1'b0;
        chk("rst_pre_outstanding", {62'd0, a_out}, 64'd2);
        chk("rst_pre_rdv", {63'd0, a_bus.readdatavalid}, 64'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_rdv_drop", {63'd0, a_bus.readdatavalid}, 64'd0);
        chk("rst_outstanding", {62'd0, a_out}, 64'd0);
        chk("rst_err_clear", {63'd0, a_err}, 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        nb = 0;
        repeat (8) begin
            @(negedge clk);
            if (a_bus.readdatavalid) nb++;
        end
        chk("rst_no_stale", 64'(nb), 64'd0);
        a_read(32'd0, d);
        chk("rst_preload_kept", d, 64'h0102030405060708);

        // In-flight limit on the second instance (no stall, latency 4).
        @(posedge clk); #1;
        b_bus.read = 1'b1; b_bus.address = 32'd0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk($sformatf("full_wait_c%0d", c), {63'd0, b_bus.waitrequest}, {63'd0, b_wr_tab[c]});
            chk($sformatf("full_rdv_c%0d", c), {63'd0, b_bus.readdatavalid}, {63'd0, b_rdv_tab[c]});
            chk($sformatf("full_out_c%0d", c), {62'd0, b_out}, 64'(b_out_tab[c]));
            if (c == 4 || c == 5) begin
                chk($sformatf("full_data_c%0d", c), b_bus.readdata, 64'hB0B0B0B0B0B0B0B0);
            end
        end
        @(posedge clk); #1;
        b_bus.read = 1'b0;
        @(negedge clk);
        chk("full_idle_wait", {63'd0, b_bus.waitrequest}, 64'd0);
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("full_drained", {62'd0, b_out}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
